// File: rtl/shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shifter_pkg
// Description : Shared types and elaboration helpers for the pipelined shifter.
// Revision    : 1.0
// ============================================================================
package shifter_pkg;

    typedef enum logic [2:0] {
        SRL = 3'd0,
        SLL = 3'd1,
        SRA = 3'd2,
        ROR = 3'd3,
        ROL = 3'd4
    } shift_mode_e;

    localparam int unsigned c_MODE_W = 3;

    // ceil(log2(width) / stages): shift levels handled by each register stage.
    function automatic int unsigned levels_per_stage(input int unsigned width,
                                                     input int unsigned stages);
        return ($clog2(width) + stages - 1) / stages;
    endfunction

    // Source bit index for bit bit_idx of a width-bit reversed word.
    function automatic int unsigned rev_index(input int unsigned bit_idx,
                                              input int unsigned width);
        return width - 1 - bit_idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shifter_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : shifter_pipe_stage
// Description : One group of right-shift/rotate levels followed by its
//               register slice and valid/advance handshake.
// Revision    : 1.0
// ============================================================================
module shifter_pipe_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int TAG_W       = 4,
    parameter int AMT_W       = 6,
    parameter int FIRST_LEVEL = 0,
    parameter int NUM_LEVELS  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_sticky,
    input  logic [2:0]       i_mode,
    input  logic [AMT_W-1:0] i_amt,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_illegal,
    input  logic             i_next_advance,
    output logic             o_advance,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_sticky,
    output logic [2:0]       o_mode,
    output logic [AMT_W-1:0] o_amt,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_illegal
);

    localparam logic [WIDTH-1:0] c_ONES = '1;

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_sticky;
    logic [2:0]       r_mode;
    logic [AMT_W-1:0] r_amt;
    logic [TAG_W-1:0] r_tag;
    logic             r_illegal;

    logic [WIDTH-1:0] w_data;
    logic [WIDTH-1:0] w_drop;
    logic             w_sticky;
    logic             w_fill;
    logic             w_rot;
    logic             w_right;
    int               w_sh;

    // Every mode is a right shift here; left modes arrive bit-reversed.
    always_comb begin
        w_data   = i_data;
        w_sticky = i_sticky;
        w_drop   = '0;
        w_fill   = 1'b0;
        w_sh     = 0;
        w_rot    = (i_mode == ROR) || (i_mode == ROL);
        w_right  = (i_mode == SRL) || (i_mode == SRA);
        for (int k = 0; k < NUM_LEVELS; k++) begin
            if (i_amt[FIRST_LEVEL + k]) begin
                w_sh   = 1 << (FIRST_LEVEL + k);
                w_fill = (i_mode == SRA) && w_data[WIDTH-1];
                w_drop = w_data & ~(c_ONES << w_sh);
                if (w_rot) begin
                    w_data = (w_data >> w_sh) | (w_data << (WIDTH - w_sh));
                end else begin
                    w_data = (w_data >> w_sh) | (w_fill ? ~(c_ONES >> w_sh) : '0);
                    if (w_right) begin
                        w_sticky = w_sticky | (|w_drop);
                    end
                end
            end
        end
    end

    assign o_advance = ~r_valid | i_next_advance;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_sticky  <= 1'b0;
            r_mode    <= '0;
            r_amt     <= '0;
            r_tag     <= '0;
            r_illegal <= 1'b0;
        end else if (o_advance) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data    <= w_data;
                r_sticky  <= w_sticky;
                r_mode    <= i_mode;
                r_amt     <= i_amt;
                r_tag     <= i_tag;
                r_illegal <= i_illegal;
            end
        end
    end

    assign o_valid   = r_valid;
    assign o_data    = r_data;
    assign o_sticky  = r_sticky;
    assign o_mode    = r_mode;
    assign o_amt     = r_amt;
    assign o_tag     = r_tag;
    assign o_illegal = r_illegal;

endmodule
`default_nettype wire

// File: rtl/shifter_pipe.sv
`default_nettype none
// ============================================================================
// Module      : shifter_pipe
// Description : Parametrised pipelined barrel shifter (SRL/SLL/SRA/ROR/ROL)
//               with sticky output and valid/ready stream handshake.
// Revision    : 1.0
// ============================================================================
module shifter_pipe
    import shifter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     data_in,
    input  logic [$clog2(WIDTH):0] shift_amount,
    input  logic [2:0]           mode,
    input  logic [TAG_W-1:0]     tag_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     data_out,
    output logic                 sticky_out,
    output logic                 illegal_out,
    output logic [TAG_W-1:0]     tag_out
);

    localparam int c_LVLS  = $clog2(WIDTH);
    localparam int c_AMT_W = c_LVLS + 1;
    localparam int c_LPS   = int'(levels_per_stage(WIDTH, STAGES));

    // Index 0 is the pipe entry, index s+1 the output of stage s.
    logic             w_valid   [STAGES+1];
    logic             w_adv     [STAGES+1];
    logic [WIDTH-1:0] w_data    [STAGES+1];
    logic             w_sticky  [STAGES+1];
    logic [2:0]       w_mode    [STAGES+1];
    logic [c_AMT_W-1:0] w_amt   [STAGES+1];
    logic [TAG_W-1:0] w_tag     [STAGES+1];
    logic             w_illegal [STAGES+1];

    logic [WIDTH-1:0]   w_in_rev;
    logic [WIDTH-1:0]   w_out_rev;
    logic [WIDTH-1:0]   w_entry_data;
    logic [c_AMT_W-1:0] w_entry_amt;
    logic               w_entry_sticky;
    logic               w_legal;
    logic               w_rot;
    logic               w_over;
    logic               w_fill;

    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign w_in_rev[i]  = data_in[rev_index(i, WIDTH)];
        assign w_out_rev[i] = w_data[STAGES][rev_index(i, WIDTH)];
    end

    // Over-range shifts collapse to a fill word up front; the levels then only
    // move fill bits, so the result and sticky stay correct.
    always_comb begin
        w_legal        = (mode <= ROL);
        w_rot          = (mode == ROR) || (mode == ROL);
        w_over         = w_legal && !w_rot && shift_amount[c_LVLS];
        w_fill         = (mode == SRA) && data_in[WIDTH-1];
        w_entry_amt    = w_legal ? shift_amount : '0;
        w_entry_sticky = w_over && ((mode == SRL) || (mode == SRA)) && (|data_in);
        if (w_over) begin
            w_entry_data = {WIDTH{w_fill}};
        end else if ((mode == SLL) || (mode == ROL)) begin
            w_entry_data = w_in_rev;
        end else begin
            w_entry_data = data_in;
        end
    end

    assign w_valid[0]      = in_valid;
    assign w_data[0]       = w_entry_data;
    assign w_sticky[0]     = w_entry_sticky;
    assign w_mode[0]       = mode;
    assign w_amt[0]        = w_entry_amt;
    assign w_tag[0]        = tag_in;
    assign w_illegal[0]    = ~w_legal;
    assign w_adv[STAGES]   = out_ready;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int c_FIRST = s * c_LPS;
        localparam int c_NUM   = (c_FIRST >= c_LVLS) ? 0 :
                                 (((c_LVLS - c_FIRST) < c_LPS) ? (c_LVLS - c_FIRST) : c_LPS);

        shifter_pipe_stage #(
            .WIDTH       (WIDTH),
            .TAG_W       (TAG_W),
            .AMT_W       (c_AMT_W),
            .FIRST_LEVEL (c_FIRST),
            .NUM_LEVELS  (c_NUM)
        ) u_stage (
            .clk            (clk),
            .rst            (rst),
            .i_valid        (w_valid[s]),
            .i_data         (w_data[s]),
            .i_sticky       (w_sticky[s]),
            .i_mode         (w_mode[s]),
            .i_amt          (w_amt[s]),
            .i_tag          (w_tag[s]),
            .i_illegal      (w_illegal[s]),
            .i_next_advance (w_adv[s+1]),
            .o_advance      (w_adv[s]),
            .o_valid        (w_valid[s+1]),
            .o_data         (w_data[s+1]),
            .o_sticky       (w_sticky[s+1]),
            .o_mode         (w_mode[s+1]),
            .o_amt          (w_amt[s+1]),
            .o_tag          (w_tag[s+1]),
            .o_illegal      (w_illegal[s+1])
        );
    end

    assign in_ready    = w_adv[0];
    assign out_valid   = w_valid[STAGES];
    assign data_out    = ((w_mode[STAGES] == SLL) || (w_mode[STAGES] == ROL)) ?
                         w_out_rev : w_data[STAGES];
    assign sticky_out  = w_sticky[STAGES];
    assign illegal_out = w_illegal[STAGES];
    assign tag_out     = w_tag[STAGES];

endmodule
`default_nettype wire

// File: tb/tb_shifter_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_shifter_pipe
// Description : Scoreboard bench for shifter_pipe (32/2 directed+random,
//               64/3 random sweep) against an arithmetic reference model.
// Revision    : 1.0
// ============================================================================
module tb_shifter_pipe;

    typedef struct packed {
        logic [127:0] data;
        logic         sticky;
        logic         ill;
        logic [3:0]   tag;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit, 2-stage instance
    logic        rst, in_valid, in_ready, out_valid, out_ready, sticky_out, illegal_out;
    logic [31:0] data_in, data_out;
    logic [5:0]  shift_amount;
    logic [2:0]  mode;
    logic [3:0]  tag_in, tag_out;

    // 64-bit, 3-stage instance
    logic        rst_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, sticky_b, illegal_b;
    logic [63:0] data_in_b, data_out_b;
    logic [6:0]  amt_b;
    logic [2:0]  mode_b;
    logic [3:0]  tag_in_b, tag_out_b;

    shifter_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(4)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .shift_amount(shift_amount), .mode(mode), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .sticky_out(sticky_out), .illegal_out(illegal_out), .tag_out(tag_out)
    );

    shifter_pipe #(.WIDTH(64), .STAGES(3), .TAG_W(4)) u_dut64 (
        .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .data_in(data_in_b), .shift_amount(amt_b), .mode(mode_b), .tag_in(tag_in_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .data_out(data_out_b),
        .sticky_out(sticky_b), .illegal_out(illegal_b), .tag_out(tag_out_b)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q32[$];
    exp_t q64[$];
    int   bp32 = 0;          // 0: always ready, 1: random, 2: held low
    bit   done64 = 1'b0;
    logic [3:0] tag32 = '0;
    logic [3:0] tag64 = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on the shift rules, width w.
    function automatic exp_t model(input logic [127:0] d, input int unsigned amt,
                                   input int unsigned md, input int unsigned w,
                                   input logic [3:0] tag);
        exp_t e;
        logic [127:0] mask;
        int unsigned k;
        mask     = (w == 128) ? '1 : ((128'd1 << w) - 128'd1);
        e.tag    = tag;
        e.ill    = 1'b0;
        e.sticky = 1'b0;
        e.data   = '0;
        case (md)
            0, 2: begin
                if (amt >= w) begin
                    e.data   = (md == 2 && d[w-1]) ? mask : '0;
                    e.sticky = |d;
                end else begin
                    e.data = d >> amt;
                    if (md == 2 && d[w-1]) e.data = e.data | (mask & ~(mask >> amt));
                    e.sticky = |(d & ((128'd1 << amt) - 128'd1));
                end
            end
            1: e.data = (amt >= w) ? '0 : ((d << amt) & mask);
            3: begin k = amt % w; e.data = ((d >> k) | (d << (w - k))) & mask; end
            4: begin k = amt % w; e.data = ((d << k) | (d >> (w - k))) & mask; end
            default: begin e.data = d; e.ill = 1'b1; end
        endcase
        return e;
    endfunction

    always @(posedge clk) begin
        #1;
        case (bp32)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
        out_ready_b = 1'($urandom_range(0, 1));
    end

    // Monitors: pop and compare on every output transfer.
    exp_t m32, m64;
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q32.size() == 0) begin
                check("dut32 unexpected beat", 128'(out_valid), 128'd0);
            end else begin
                m32 = q32.pop_front();
                check("dut32 data",    128'(data_out),    m32.data);
                check("dut32 sticky",  128'(sticky_out),  128'(m32.sticky));
                check("dut32 illegal", 128'(illegal_out), 128'(m32.ill));
                check("dut32 tag",     128'(tag_out),     128'(m32.tag));
            end
        end
        if (!rst_b && out_valid_b && out_ready_b) begin
            if (q64.size() == 0) begin
                check("dut64 unexpected beat", 128'(out_valid_b), 128'd0);
            end else begin
                m64 = q64.pop_front();
                check("dut64 data",    128'(data_out_b), m64.data);
                check("dut64 sticky",  128'(sticky_b),   128'(m64.sticky));
                check("dut64 illegal", 128'(illegal_b),  128'(m64.ill));
                check("dut64 tag",     128'(tag_out_b),  128'(m64.tag));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send32(input logic [31:0] d, input logic [5:0] amt,
                          input logic [2:0] md, input exp_t e);
        int n = 0;
        in_valid = 1'b1; data_in = d; shift_amount = amt; mode = md; tag_in = e.tag;
        forever begin
            @(negedge clk);
            if (in_ready) begin q32.push_back(e); break; end
            n++;
            if (n > 200) begin check("dut32 in_ready timeout", 128'd0, 128'd1); break; end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic dir32(input logic [31:0] d, input logic [5:0] amt, input logic [2:0] md,
                         input logic [31:0] xd, input logic xs, input logic xi);
        exp_t e;
        e.data = 128'(xd); e.sticky = xs; e.ill = xi; e.tag = tag32;
        tag32++;
        send32(d, amt, md, e);
    endtask

    task automatic rnd32();
        logic [31:0] d;
        logic [5:0]  a;
        logic [2:0]  m;
        d = $urandom;
        a = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(32, 63)) : 6'($urandom_range(0, 31));
        m = 3'($urandom_range(0, 7));
        send32(d, a, m, model(128'(d), a, m, 32, tag32));
        tag32++;
    endtask

    task automatic send64(input logic [63:0] d, input logic [6:0] amt, input logic [2:0] md);
        int n = 0;
        in_valid_b = 1'b1; data_in_b = d; amt_b = amt; mode_b = md; tag_in_b = tag64;
        forever begin
            @(negedge clk);
            if (in_ready_b) begin q64.push_back(model(128'(d), amt, md, 64, tag64)); break; end
            n++;
            if (n > 200) begin check("dut64 in_ready timeout", 128'd0, 128'd1); break; end
        end
        tag64++;
        @(posedge clk); #1;
        in_valid_b = 1'b0;
    endtask

    task automatic drain32();
        int n = 0;
        while (q32.size() != 0 && n < 500) begin @(posedge clk); n++; end
        check("dut32 drain", 128'(q32.size()), 128'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_b = 1'b1; in_valid_b = 1'b0; data_in_b = '0; amt_b = '0; mode_b = '0; tag_in_b = '0;
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b0;
        for (int i = 0; i < 300; i++) begin
            send64({$urandom, $urandom}, 7'($urandom_range(0, 127)), 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        done64 = 1'b1;
    end

    initial begin
        int lat;
        int n;
        rst = 1'b1; in_valid = 1'b0; data_in = '0; shift_amount = '0; mode = '0; tag_in = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("reset out_valid", 128'(out_valid),   128'd0);
        check("reset in_ready",  128'(in_ready),    128'd1);
        check("reset data_out",  128'(data_out),    128'd0);
        check("reset sticky",    128'(sticky_out),  128'd0);
        check("reset illegal",   128'(illegal_out), 128'd0);
        check("reset tag",       128'(tag_out),     128'd0);
        @(posedge clk); #1;

        // Latency on an empty pipe
        dir32(32'h8000_00F0, 6'd4, 3'd2, 32'hF800_000F, 1'b0, 1'b0);
        lat = 1;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        check("latency", 128'(lat), 128'd2);
        drain32();

        dir32(32'h8000_00F0, 6'd5,  3'd2, 32'hFC00_0007, 1'b1, 1'b0);
        dir32(32'h0000_0001, 6'd31, 3'd1, 32'h8000_0000, 1'b0, 1'b0);
        dir32(32'h8000_0001, 6'd1,  3'd4, 32'h0000_0003, 1'b0, 1'b0);
        dir32(32'h0000_0010, 6'd32, 3'd0, 32'h0000_0000, 1'b1, 1'b0);
        dir32(32'h8000_0000, 6'd40, 3'd2, 32'hFFFF_FFFF, 1'b1, 1'b0);
        dir32(32'h1234_5678, 6'd9,  3'd6, 32'h1234_5678, 1'b0, 1'b1);
        dir32(32'hDEAD_BEEF, 6'd0,  3'd3, 32'hDEAD_BEEF, 1'b0, 1'b0);
        dir32(32'hDEAD_BEEF, 6'd36, 3'd3, 32'hFDEA_DBEE, 1'b0, 1'b0);
        dir32(32'h0000_00FF, 6'd33, 3'd1, 32'h0000_0000, 1'b0, 1'b0);
        drain32();

        // Full pipe held by out_ready low
        bp32 = 2;
        @(posedge clk); #1;
        rnd32();
        rnd32();
        in_valid = 1'b1; data_in = 32'hA5A5_0F0F; shift_amount = 6'd3; mode = 3'd0; tag_in = tag32;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall in_ready",  128'(in_ready),  128'd0);
            check("stall out_valid", 128'(out_valid), 128'd1);
            check("stall data_out",  128'(data_out),  q32[0].data);
            check("stall tag_out",   128'(tag_out),   128'(q32[0].tag));
        end
        @(posedge clk); #1;
        bp32 = 0;
        send32(32'hA5A5_0F0F, 6'd3, 3'd0, model(128'(32'hA5A5_0F0F), 3, 0, 32, tag32));
        tag32++;
        drain32();

        // Random stream with 50% back-pressure
        bp32 = 1;
        for (int i = 0; i < 200; i++) begin
            rnd32();
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        bp32 = 0;
        drain32();

        // Reset with beats in flight
        bp32 = 2;
        @(posedge clk); #1;
        rnd32();
        rnd32();
        rst = 1'b1;
        q32.delete();
        @(posedge clk); #1;
        @(negedge clk);
        check("rst flush out_valid", 128'(out_valid), 128'd0);
        check("rst flush in_ready",  128'(in_ready),  128'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        bp32 = 0;
        @(negedge clk);
        check("post-rst in_ready",  128'(in_ready),  128'd1);
        check("post-rst out_valid", 128'(out_valid), 128'd0);
        @(posedge clk); #1;
        dir32(32'h0F00_0000, 6'd8, 3'd0, 32'h000F_0000, 1'b0, 1'b0);
        drain32();

        n = 0;
        while ((!done64 || q64.size() != 0) && n < 5000) begin @(posedge clk); n++; end
        check("dut64 drain", 128'(q64.size()), 128'd0);
        check("dut64 done",  128'(done64),     128'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
